// File: rtl/keypad_emulator.sv
// Behavioural 4x4 keypad: queues key codes and presses them one at a time,
// answering one-hot column strobes with the matching one-hot row line.
module keypad_emulator #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    output logic [3:0] row,
    output logic       busy,
    output logic       key_done,
    output logic [7:0] keys_sent
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [3:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_strobe_seen;
    logic [3:0]          r_cur_key;
    logic                r_key_done;
    logic [7:0]          r_keys_sent;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [3:0]          w_col_onehot;
    logic [3:0]          w_row_onehot;
    logic                w_match;
    logic                w_hold_done;
    logic                w_gap_done;
    logic                w_press_exit;

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    // Push is gated by full alone; a same-cycle pop does not open a slot.
    assign w_push       = key_valid && !w_full;
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_col_onehot = 4'b1000 >> r_cur_key[1:0];
    assign w_row_onehot = 4'b1000 >> r_cur_key[3:2];
    assign w_match      = (r_state == S_PRESS) && (col == w_col_onehot);
    assign w_hold_done  = (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign w_gap_done   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_press_exit = (r_state == S_PRESS) && w_hold_done && (r_strobe_seen || w_match);

    // NOTE: storage array carries no reset; r_count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_code;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaulting w_next_state before the case keeps this block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_PRESS;
                end
            end
            S_PRESS: begin
                if (w_press_exit) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_gap_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_strobe_seen <= 1'b0;
            r_cur_key     <= '0;
            r_key_done    <= 1'b0;
            r_keys_sent   <= '0;
        end else begin
            if (w_pop) begin
                r_cur_key     <= r_mem[r_rd_ptr];
                r_hold_cnt    <= '0;
                r_strobe_seen <= 1'b0;
            end else if (r_state == S_PRESS) begin
                // Saturate so a stalled scanner keeps the key held indefinitely.
                if (!w_hold_done) begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                end
                if (w_match) begin
                    r_strobe_seen <= 1'b1;
                end
            end

            if (w_press_exit) begin
                r_gap_cnt <= '0;
            end else if ((r_state == S_RELEASE) && !w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end

            r_key_done <= (r_state == S_RELEASE) && w_gap_done;
            if ((r_state == S_RELEASE) && w_gap_done) begin
                r_keys_sent <= r_keys_sent + 8'd1;
            end
        end
    end

    always_comb begin
        row       = w_match ? w_row_onehot : 4'b0000;
        key_ready = !w_full;
        busy      = (r_state != S_IDLE) || !w_empty;
        key_done  = r_key_done;
        keys_sent = r_keys_sent;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: reset, single press, stalled scanner with
// backpressure and passcode replay, illegal strobes, mid-press reset, counter wrap.
module tb_keypad_emulator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] col = 4'b0000;
    logic [3:0] key_code = 4'b0000;
    logic       key_valid = 1'b0;
    logic       key_ready;
    logic [3:0] row;
    logic       busy;
    logic       key_done;
    logic [7:0] keys_sent;

    int total = 0;
    int bad = 0;

    logic [3:0] s_row;
    logic       s_ready;
    logic       s_busy;
    logic       s_done;
    logic [7:0] s_sent;

    keypad_emulator #(.DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .row       (row),
        .busy      (busy),
        .key_done  (key_done),
        .keys_sent (keys_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Inputs change on the falling edge; outputs are captured 1 ns later.
    task automatic step(input logic [3:0] c, input logic kv, input logic [3:0] kc);
        @(negedge clk);
        col = c;
        key_valid = kv;
        key_code = kc;
        #1;
        s_row = row;
        s_ready = key_ready;
        s_busy = busy;
        s_done = key_done;
        s_sent = keys_sent;
    endtask

    function automatic logic [3:0] rot(input int k);
        logic [3:0] b;
        b = 4'b1000;
        return b >> (k % 4);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        col = 4'b1000;
        key_valid = 1'b1;
        key_code = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        total++; if (row !== 4'b0000) begin bad++; $display("FAIL reset_row got=%b want=0000", row); end
        total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", key_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (key_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", key_done); end
        total++; if (keys_sent !== 8'd0) begin bad++; $display("FAIL reset_sent got=%0d want=0", keys_sent); end
        @(negedge clk);
        key_valid = 1'b0;
        rst = 1'b1;
        step(4'b0000, 1'b0, 4'b0000);
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", s_busy); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", s_ready); end
    endtask

    // Push at step 0, pop at step 1, PRESS steps 2..9, RELEASE 10..17, done at 18.
    task automatic test_single_key();
        logic [3:0] exp_row;
        for (int k = 0; k < 20; k++) begin
            step(rot(k), (k == 0), 4'b1001);
            exp_row = (k >= 2 && k <= 9 && rot(k) == 4'b0100) ? 4'b0010 : 4'b0000;
            total++; if (s_row !== exp_row) begin bad++; $display("FAIL single_row step=%0d got=%b want=%b", k, s_row, exp_row); end
            total++; if (s_done !== (k == 18)) begin bad++; $display("FAIL single_done step=%0d got=%b want=%b", k, s_done, (k == 18)); end
            total++; if (s_busy !== (k >= 1 && k <= 17)) begin bad++; $display("FAIL single_busy step=%0d got=%b", k, s_busy); end
            total++; if (s_sent !== ((k >= 18) ? 8'd1 : 8'd0)) begin bad++; $display("FAIL single_sent step=%0d got=%0d", k, s_sent); end
        end
    endtask

    task automatic test_stall_backpressure_passcode();
        logic [3:0] pass [4];
        logic [7:0] exp_seq [5];
        logic [7:0] seen [$];
        logic       prev_done;
        int         pulses;
        pass = '{4'b0000, 4'b1001, 4'b0110, 4'b0101};
        exp_seq = '{8'h88, 8'h42, 8'h24, 8'h44, 8'h11};

        // Stall key 0000 enters PRESS while the scanner sits on col 3.
        step(4'b0001, 1'b1, 4'b0000);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stall_ready0 got=%b want=1", s_ready); end
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 1'b1, pass[i]);
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL pass_push_ready i=%0d got=%b want=1", i, s_ready); end
        end
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 1'b1, 4'b1111);
            total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready i=%0d got=%b want=0", i, s_ready); end
            total++; if (s_row !== 4'b0000) begin bad++; $display("FAIL stall_row i=%0d got=%b want=0000", i, s_row); end
            total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL stall_busy i=%0d got=%b want=1", i, s_busy); end
        end
        step(4'b1000, 1'b1, 4'b1111);
        total++; if (s_row !== 4'b1000) begin bad++; $display("FAIL stall_release_row got=%b want=1000", s_row); end
        for (int i = 0; i < 8; i++) begin
            step(4'b1000, 1'b1, 4'b1111);
            total++; if (s_row !== 4'b0000) begin bad++; $display("FAIL gap_row i=%0d got=%b want=0000", i, s_row); end
            total++; if (s_done !== 1'b0) begin bad++; $display("FAIL gap_done i=%0d got=%b want=0", i, s_done); end
        end
        // Pop happens at this edge but the held key must not be written yet.
        step(4'b1000, 1'b1, 4'b1111);
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", s_done); end
        total++; if (s_sent !== 8'd2) begin bad++; $display("FAIL stall_sent got=%0d want=2", s_sent); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL pop_edge_ready got=%b want=0", s_ready); end

        prev_done = 1'b1;
        pulses = 0;
        for (int j = 0; j < 300 && pulses < 5; j++) begin
            step(rot(j), (j == 0), 4'b1111);
            if (j == 0) begin
                total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL held_push_ready got=%b want=1", s_ready); end
            end
            if (j == 1) begin
                total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL refull_ready got=%b want=0", s_ready); end
            end
            if (s_row !== 4'b0000) begin
                if (seen.size() == 0 || seen[$] !== {col, s_row}) seen.push_back({col, s_row});
            end
            if (s_done) begin
                pulses++;
                total++; if (prev_done !== 1'b0) begin bad++; $display("FAIL done_width j=%0d got=%b want=0", j, prev_done); end
            end
            prev_done = s_done;
        end
        total++; if (pulses != 5) begin bad++; $display("FAIL replay_timeout got=%0d want=5", pulses); end
        total++; if (seen.size() != 5) begin bad++; $display("FAIL replay_count got=%0d want=5", seen.size()); end
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            total++; if (seen[i] !== exp_seq[i]) begin bad++; $display("FAIL replay_order i=%0d got=%h want=%h", i, seen[i], exp_seq[i]); end
        end
        total++; if (s_sent !== 8'd7) begin bad++; $display("FAIL replay_sent got=%0d want=7", s_sent); end
    endtask

    task automatic test_illegal_col();
        logic [3:0] bad_cols [4];
        int         waited;
        bad_cols = '{4'b0110, 4'b0000, 4'b1111, 4'b0011};
        step(4'b0000, 1'b1, 4'b0110);
        step(4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(bad_cols[i], 1'b0, 4'b0000);
            total++; if (s_row !== 4'b0000) begin bad++; $display("FAIL illegal_row col=%b got=%b want=0000", bad_cols[i], s_row); end
            total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL illegal_busy col=%b got=%b want=1", bad_cols[i], s_busy); end
        end
        step(4'b0010, 1'b0, 4'b0000);
        total++; if (s_row !== 4'b0100) begin bad++; $display("FAIL legal_row got=%b want=0100", s_row); end
        waited = 0;
        do begin
            step(4'b0000, 1'b0, 4'b0000);
            waited++;
        end while (!s_done && waited < 40);
        total++; if (s_done !== 1'b1) begin bad++; $display("FAIL illegal_timeout got=%b want=1", s_done); end
        total++; if (s_sent !== 8'd8) begin bad++; $display("FAIL illegal_sent got=%0d want=8", s_sent); end
    endtask

    task automatic test_reset_mid_press();
        step(4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 1'b1, 4'b0101);
        step(4'b1000, 1'b1, 4'b1010);
        total++; if (s_row !== 4'b1000) begin bad++; $display("FAIL pre_reset_row got=%b want=1000", s_row); end
        key_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        total++; if (row !== 4'b0000) begin bad++; $display("FAIL mid_reset_row got=%b want=0000", row); end
        total++; if (keys_sent !== 8'd0) begin bad++; $display("FAIL mid_reset_sent got=%0d want=0", keys_sent); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
        @(negedge clk);
        rst = 1'b1;
        step(4'b1000, 1'b0, 4'b0000);
        total++; if (s_row !== 4'b0000) begin bad++; $display("FAIL after_reset_row got=%b want=0000", s_row); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL after_reset_busy got=%b want=0", s_busy); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL after_reset_ready got=%b want=1", s_ready); end
    endtask

    task automatic test_wrap();
        int pushed;
        int pulses;
        logic kv;
        pushed = 0;
        pulses = 0;
        for (int j = 0; j < 6000 && pulses < 256; j++) begin
            kv = (pushed < 256);
            step(4'b1000, kv, 4'b0000);
            if (kv && s_ready) pushed++;
            if (s_done) begin
                pulses++;
                total++; if (s_sent !== 8'(pulses)) begin bad++; $display("FAIL wrap_sent n=%0d got=%0d want=%0d", pulses, s_sent, 8'(pulses)); end
            end
        end
        total++; if (pulses != 256) begin bad++; $display("FAIL wrap_timeout got=%0d want=256", pulses); end
        total++; if (s_sent !== 8'd0) begin bad++; $display("FAIL wrap_final got=%0d want=0", s_sent); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL wrap_busy got=%b want=0", s_busy); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_stall_backpressure_passcode();
        test_illegal_col();
        test_reset_mid_press();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
